vga_fb_arbiter: RTL

Shares one single-port synchronous framebuffer RAM between the VGA scan-out path and a drawing-engine writer. Sits between `VGA_controller` (consumes its `display_enable`, `row`, `column`) and the video RAM, and produces the pixel stream for the DAC. Display reads have absolute priority. Writes use the remaining cycles through a req/ack handshake.

---
 rtl/vga_fb_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer arbiter: VGA scan-out reads win, writer gets spare cycles
// Optional bank double-buffering is enabled by defining VGA_FB_DOUBLE_BUFFER_EN.
module vga_fb_arbiter #(
   parameter int FB_W        = 160,
   parameter int FB_H        = 120,
   parameter int SCALE_SHIFT = 2,
   parameter int ADDR_W      = 15,
   parameter int DATA_W      = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              display_enable,
   input  logic [15:0]       row,
   input  logic [15:0]       column,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              wr_err,
   input  logic              swap_req,
   output logic              swap_done,
`ifdef VGA_FB_DOUBLE_BUFFER_EN
   output logic [ADDR_W:0]   mem_addr,
`else
   output logic [ADDR_W-1:0] mem_addr,
`endif
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid
);
   typedef enum logic [1:0] {IDLE, DISP_RD, WR} state_t;

`ifdef VGA_FB_DOUBLE_BUFFER_EN
   localparam int MA_W = ADDR_W + 1;
`else
   localparam int MA_W = ADDR_W;
`endif
   localparam logic [15:0]            ROW_LIM    = 16'(FB_H << SCALE_SHIFT);
   localparam logic [ADDR_W:0]        FB_SIZE    = (ADDR_W+1)'(FB_W * FB_H);
   localparam logic [SCALE_SHIFT-1:0] ZERO_PHASE = '0;

   state_t            state;
   logic              disp_slot;
   logic              addr_err;
   logic              rd_d1;
   logic              de_d1;
   logic              de_d2;
   logic [ADDR_W-1:0] disp_row;
   logic [ADDR_W-1:0] disp_col;
   logic [ADDR_W-1:0] disp_addr;
   logic [MA_W-1:0]   rd_full;
   logic [MA_W-1:0]   wr_full;

   assign disp_slot = display_enable && (row < ROW_LIM) && (column[SCALE_SHIFT-1:0] == ZERO_PHASE);
   assign disp_row  = ADDR_W'(row >> SCALE_SHIFT);
   assign disp_col  = ADDR_W'(column >> SCALE_SHIFT);
   assign disp_addr = ADDR_W'(disp_row * ADDR_W'(FB_W)) + disp_col;
   assign addr_err  = {1'b0, wr_addr} >= FB_SIZE;

`ifdef VGA_FB_DOUBLE_BUFFER_EN
   logic disp_bank;
   logic swap_pend;
   logic swap_now;
   logic bank_nxt;

   // The (0,0) read itself already uses the new bank, so the swap is frame-exact.
   assign swap_now = swap_pend && (row == 16'd0) && (column == 16'd0);
   assign bank_nxt = disp_bank ^ swap_now;
   assign rd_full  = {bank_nxt, disp_addr};
   assign wr_full  = {~bank_nxt, wr_addr};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         disp_bank <= 1'b0;
         swap_pend <= 1'b0;
         swap_done <= 1'b0;
      end else begin
         disp_bank <= bank_nxt;
         swap_done <= swap_now;
         if (swap_now)
            swap_pend <= swap_req;
         else if (swap_req)
            swap_pend <= 1'b1;
      end
   end
`else
   logic swap_unused;
   assign swap_unused = swap_req;
   assign swap_done   = 1'b0;
   assign rd_full     = disp_addr;
   assign wr_full     = wr_addr;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         wr_ack    <= 1'b0;
         wr_err    <= 1'b0;
      end else if (disp_slot) begin
         state    <= DISP_RD;
         mem_addr <= rd_full;
         mem_we   <= 1'b0;
         wr_ack   <= 1'b0;
         wr_err   <= 1'b0;
      end else if (wr_req && state != WR) begin
         state     <= WR;
         mem_addr  <= wr_full;
         mem_we    <= !addr_err;
         mem_wdata <= wr_data;
         wr_ack    <= 1'b1;
         wr_err    <= addr_err;
      end else begin
         state  <= IDLE;
         mem_we <= 1'b0;
         wr_ack <= 1'b0;
         wr_err <= 1'b0;
      end
   end

   // RAM data arrives one cycle after DISP_RD; visibility is delayed to match.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_d1     <= 1'b0;
         de_d1     <= 1'b0;
         de_d2     <= 1'b0;
         pix_data  <= '0;
         pix_valid <= 1'b0;
      end else begin
         rd_d1     <= (state == DISP_RD);
         de_d1     <= display_enable;
         de_d2     <= de_d1;
         pix_valid <= de_d2;
         if (!de_d2)
            pix_data <= '0;
         else if (rd_d1)
            pix_data <= mem_rdata;
      end
   end
endmodule
